// File: rtl/four_to_one_mux_round_robin_arbiter_module_if.sv
// Requester-side bundle for the 4:1 mux arbiter: request vector in, grant and mux selects out.
interface four_to_one_mux_round_robin_arbiter_module_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s0;
  logic       s1;
  logic       busy;

  modport master (
    output req,
    input  gnt,
    input  s0,
    input  s1,
    input  busy
  );

  modport slave (
    input  req,
    output gnt,
    output s0,
    output s1,
    output busy
  );
endinterface

// File: rtl/four_to_one_mux_round_robin_arbiter_module.sv
// Round-robin arbiter with bounded bursts; its registered owner index drives the 4:1 mux selects.
module four_to_one_mux_round_robin_arbiter_module #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  four_to_one_mux_round_robin_arbiter_module_if.slave bus
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [3:0] gnt_q,   gnt_d;

  logic [1:0] pick_s;
  logic       any_req_s;
  logic       tenure_end_s;

  // Search starts one past the last owner and reaches the last owner only at the end.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return pick;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Arbitration decode and tenure-end detection.
  always_comb begin
    pick_s       = rr_pick(bus.req, owner_q);
    any_req_s    = (bus.req != 4'b0000);
    tenure_end_s = (!bus.req[owner_q]) || (cnt_q == MAX_BURST_C);
  end

  // Next-state logic: grant, hold, hand over or release.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          owner_d = pick_s;
          gnt_d   = onehot(pick_s);
          cnt_d   = 4'd1;
          state_d = BUSY;
        end else begin
          gnt_d   = 4'b0000;
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!tenure_end_s) begin
          cnt_d = cnt_q + 4'd1;
        end else if (any_req_s) begin
          // Handover happens in the same edge, so the mux never sees an idle gap.
          owner_d = pick_s;
          gnt_d   = onehot(pick_s);
          cnt_d   = 4'd1;
          state_d = BUSY;
        end else begin
          gnt_d   = 4'b0000;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        owner_d = 2'd3;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State registers; owner resets to 3 so requester 0 wins the first arbitration.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 2'd3;
      cnt_q   <= 4'd0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.s0   = owner_q[0];
  assign bus.s1   = owner_q[1];
  assign bus.busy = (state_q == BUSY);

endmodule

// File: tb/tb_four_to_one_mux_round_robin_arbiter_module.sv
// Random and directed bench for the round-robin arbiter, run at MAX_BURST 4 and 1 side by side.
module tb_four_to_one_mux_round_robin_arbiter_module;
  logic clk;
  logic rst;

  four_to_one_mux_round_robin_arbiter_module_if if4 ();
  four_to_one_mux_round_robin_arbiter_module_if if1 ();

  four_to_one_mux_round_robin_arbiter_module #(.MAX_BURST(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .bus(if4.slave)
  );
  four_to_one_mux_round_robin_arbiter_module #(.MAX_BURST(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: unit 0 has MAX_BURST 4, unit 1 has MAX_BURST 1.
  int m_owner [2];
  int m_cnt   [2];
  bit m_busy  [2];
  int m_max   [2] = '{4, 1};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u] = 3;
      m_cnt[u]   = 0;
      m_busy[u]  = 1'b0;
    end
  endtask

  task automatic model_grant(input int u, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(m_owner[u] + k) % 4]) begin
        m_owner[u] = (m_owner[u] + k) % 4;
        m_cnt[u]   = 1;
        m_busy[u]  = 1'b1;
        return;
      end
    end
  endtask

  task automatic model_step(input int u, input logic [3:0] r);
    if (!m_busy[u]) begin
      if (r != 4'b0000) model_grant(u, r);
    end else if (r[m_owner[u]] && m_cnt[u] < m_max[u]) begin
      m_cnt[u]++;
    end else if (r != 4'b0000) begin
      model_grant(u, r);
    end else begin
      m_busy[u] = 1'b0;
    end
  endtask

  task automatic check_unit(input int u);
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic [3:0] eg;
    if (u == 0) begin
      g = if4.gnt; s = {if4.s1, if4.s0}; b = if4.busy;
    end else begin
      g = if1.gnt; s = {if1.s1, if1.s0}; b = if1.busy;
    end
    eg = m_busy[u] ? (4'b0001 << m_owner[u]) : 4'b0000;
    check_eq($sformatf("u%0d_gnt", u), {28'd0, g}, {28'd0, eg});
    check_eq($sformatf("u%0d_sel", u), {30'd0, s}, 32'(m_owner[u]));
    check_eq($sformatf("u%0d_busy", u), {31'd0, b}, {31'd0, m_busy[u]});
    check_eq($sformatf("u%0d_onehot0", u), {31'd0, ($countones(g) <= 1)}, 32'd1);
    check_eq($sformatf("u%0d_gnt_owner", u), {31'd0, g[s]}, {31'd0, b});
  endtask

  task automatic cycle(input logic [3:0] r4, input logic [3:0] r1);
    if4.req = r4;
    if1.req = r1;
    @(posedge clk);
    model_step(0, r4);
    model_step(1, r1);
    @(negedge clk);
    check_unit(0);
    check_unit(1);
  endtask

  // Reset pulse strictly between clock edges; outputs must drop without any edge.
  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_gnt4", {28'd0, if4.gnt}, 32'd0);
    check_eq("rst_gnt1", {28'd0, if1.gnt}, 32'd0);
    check_eq("rst_sel4", {30'd0, if4.s1, if4.s0}, 32'd3);
    check_eq("rst_busy4", {31'd0, if4.busy}, 32'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [3:0] r4, r1;
    int hold;
    rst = 1'b1;
    if4.req = 4'b0000;
    if1.req = 4'b0000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_unit(0);
    check_unit(1);
    rst = 1'b0;

    // Full contention: 4-cycle tenures rotating 0,1,2,3,0.
    for (int i = 0; i < 20; i++) begin
      cycle(4'b1111, 4'b1111);
      check_eq("A_gnt", {28'd0, if4.gnt}, 32'd1 << ((i / 4) % 4));
      check_eq("A_busy", {31'd0, if4.busy}, 32'd1);
    end

    // Early release of requester 2.
    cycle(4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      cycle((i < 2) ? 4'b0100 : 4'b0000, 4'b0000);
      check_eq("B_gnt", {28'd0, if4.gnt}, (i < 2) ? 32'h4 : 32'h0);
      check_eq("B_sel", {30'd0, if4.s1, if4.s0}, 32'd2);
      check_eq("B_busy", {31'd0, if4.busy}, (i < 2) ? 32'd1 : 32'd0);
    end

    // Sole requester keeps the grant across tenure boundaries.
    for (int i = 0; i < 10; i++) begin
      cycle(4'b1000, 4'b1000);
      check_eq("C_gnt", {28'd0, if4.gnt}, 32'h8);
    end

    // Handover from 0 to 1 with no gap.
    cycle(4'b0000, 4'b0000);
    cycle(4'b0011, 4'b0000);
    check_eq("D_gnt0", {28'd0, if4.gnt}, 32'h1);
    cycle(4'b0010, 4'b0000);
    check_eq("D_gnt1", {28'd0, if4.gnt}, 32'h2);
    check_eq("D_busy", {31'd0, if4.busy}, 32'd1);

    // Async reset in the middle of requester 1's burst.
    cycle(4'b0010, 4'b0010);
    check_eq("E_pre", {28'd0, if4.gnt}, 32'h2);
    pulse_reset();
    cycle(4'b1111, 4'b1111);
    check_eq("E_post", {28'd0, if4.gnt}, 32'h1);

    // MAX_BURST 1 alternates between requesters 0 and 2.
    @(negedge clk);
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(4'b0000, 4'b0101);
      check_eq("F_gnt", {28'd0, if1.gnt}, (i % 2 == 0) ? 32'h1 : 32'h4);
    end

    // Random requests with random hold times and occasional reset pulses.
    hold = 0;
    r4 = 4'b0000;
    r1 = 4'b0000;
    for (int i = 0; i < 500; i++) begin
      if (hold == 0) begin
        r4   = 4'($urandom_range(0, 15));
        r1   = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 7);
      end
      hold--;
      cycle(r4, r1);
      if ($urandom_range(0, 79) == 0) pulse_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/four_to_one_mux_round_robin_arbiter_module.md
# four_to_one_mux_round_robin_arbiter_module

Round-robin arbiter that shares the 4:1 gate-level mux datapath among four requesters. It registers a one-hot grant and drives the mux select lines s1:s0 so that the granted requester's input reaches the mux output. Each grant is held for a bounded burst. It sits directly in front of the mux select inputs and replaces hard-wired select control.

## Interface
- MAX_BURST, 4: maximum consecutive granted cycles per tenure. Legal range 1..15.
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  4  request vector; req[0]..req[3] correspond to mux inputs a, b, c, d
- gnt  output  4  registered one-hot grant; all zeros when idle
- s0  output  1  mux select bit 0 (LSB of owner index)
- s1  output  1  mux select bit 1 (MSB of owner index)
- busy  output  1  high while any grant is active

## Operation
- State machine with two states: IDLE and BUSY. Internal registers:
  - owner[1:0]: current or last granted index.
  - cnt[3:0]: granted cycles so far in this tenure.
- Arbitration (combinational pick, registered result):
  - Search req starting at index owner+1 mod 4, wrapping, then through owner itself last.
  - The first set bit wins. The previous owner therefore has the lowest priority.
- IDLE:
  - If req == 0: stay in IDLE; gnt = 0.
  - If req != 0: the pick becomes owner; gnt = onehot(pick); cnt = 1; go to BUSY.
- BUSY, with the current tenure ending when req[owner] == 0 or cnt == MAX_BURST:
  - If the tenure is not ending: hold owner and gnt; cnt = cnt + 1.
  - If the tenure is ending and req != 0: re-arbitrate. The new owner gets gnt, cnt = 1, and the state stays BUSY.
    - Handover has no idle gap.
    - If the old owner is the only requester, it is re-granted with cnt = 1.
  - If the tenure is ending and req == 0: gnt = 0; go to IDLE; owner is retained for priority.
- Select outputs:
  - {s1, s0} = owner at all times, including in IDLE. In IDLE the value is "don't care" to the consumer, but it must hold steady.
  - Select encoding matches the mux: 00 selects a, 01 selects b, 10 selects c, 11 selects d.
- busy = (state == BUSY).
- Invariants:
  - gnt is always zero or one-hot.
  - gnt[owner] == busy.
  - cnt never exceeds MAX_BURST.
- Requests are level-sensitive. There is no request latching: a req pulse that drops before it is granted is lost.

## Timing
- Reset, asserted asynchronously:
  - state = IDLE, gnt = 0000, owner = 3 (so req[0] has first priority), cnt = 0, busy = 0.
  - Because owner = 3, {s1, s0} = 11 during reset.
- Reset mid-burst drops the grant immediately and without waiting for a clock edge. The first edge after reset deasserts arbitrates from owner = 3.
- Latency:
  - req asserted before edge N gives gnt at edge N (valid in cycle N+1).
  - Release uses req sampled at an edge; the grant clears or moves at that same edge.
- Maximum tenure is MAX_BURST cycles.
- With MAX_BURST = 1, the grant rotates every cycle among the active requesters.
- Simultaneous requests are resolved only by the rotating priority. The worst-case wait for any continuously asserted request is 3 × MAX_BURST cycles.
- s0, s1 and gnt come straight from flops, with no combinational path from req.

## Test plan
- Reset and priority:
  - Stimulus: assert reset, release it, then hold req = 1111 with MAX_BURST = 4.
  - Required response: gnt = 0001 for 4 cycles, then 0010, 0100, 1000, 0001, each for 4 cycles. {s1, s0} follows 00, 01, 10, 11; busy stays 1 throughout.
- Early release:
  - Stimulus: req = 0100 for 2 cycles, then req = 0000.
  - Required response: gnt = 0100 for 2 cycles with {s1, s0} = 10, then gnt = 0000 and busy = 0. {s1, s0} stays 10.
- Sole requester re-grant:
  - Stimulus: req = 1000 held for 10 cycles with MAX_BURST = 4.
  - Required response: gnt = 1000 continuously, with no gap at cycles 4 and 8. cnt wraps 4 → 1.
- Handover with no gap:
  - Stimulus: req = 0011; owner 0 drops req[0] after 1 cycle.
  - Required response: gnt goes 0001 → 0010 on consecutive cycles; busy never drops.
- Asynchronous reset mid-burst:
  - Stimulus: grant 0010 active; pulse reset between clock edges.
  - Required response: gnt = 0000 immediately. Next arbitration with req = 1111 grants 0001.
- MAX_BURST = 1 fairness:
  - Stimulus: req = 0101 held for 8 cycles.
  - Required response: gnt alternates 0001, 0100, 0001, 0100, and so on. A one-hot checker and the gnt[owner] == busy check run throughout all tests.
